// File: rtl/tsu_pkg.sv
// Shared definitions for the TSU queue reader: entry field layout, host register map, FSM states.
package tsu_pkg;

    localparam int ENTRY_W    = 128;
    localparam int TS_W       = 80;

    localparam int SEQID_LSB  = 0;
    localparam int SEQID_W    = 16;
    localparam int CKSUM_LSB  = 16;
    localparam int CKSUM_W    = 12;
    localparam int MSGID_LSB  = 28;
    localparam int MSGID_W    = 4;
    localparam int NS_LSB     = 32;
    localparam int NS_W       = 32;
    localparam int SEC_LSB    = 64;
    localparam int SEC_W      = 48;

    localparam int TS_NS_LSB  = 0;
    localparam int TS_SEC_LSB = 32;

    localparam logic [2:0] ADDR_STAT       = 3'd0;
    localparam logic [2:0] ADDR_RX_SEC_HI  = 3'd1;
    localparam logic [2:0] ADDR_RX_SEC_LO  = 3'd2;
    localparam logic [2:0] ADDR_RX_NS      = 3'd3;
    localparam logic [2:0] ADDR_ID         = 3'd4;
    localparam logic [2:0] ADDR_MSG_SEC_HI = 3'd5;
    localparam logic [2:0] ADDR_MSG_SEC_LO = 3'd6;
    localparam logic [2:0] ADDR_MSG_NS     = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_WAIT,
        ST_CAPT,
        ST_HOLD
    } tsu_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/tsu_q_regbank.sv
// Holding registers for one popped queue entry, host read mux and the lost-entry counter.
import tsu_pkg::*;

module tsu_q_regbank (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               capture_i,
    input  logic               hold_i,
    input  logic               entry_valid_i,
    input  logic [7:0]         q_rd_stat_i,
    input  logic [ENTRY_W-1:0] q_rd_data_i,
    input  logic [TS_W-1:0]    q_ts_data_i,
    input  logic               host_rd_i,
    input  logic [2:0]         host_addr_i,
    output logic [31:0]        host_rd_data_o
);

    logic [SEC_W-1:0]   rx_sec_q;
    logic [NS_W-1:0]    rx_ns_q;
    logic [MSGID_W-1:0] msgid_q;
    logic [CKSUM_W-1:0] cksum_q;
    logic [SEQID_W-1:0] seqid_q;
    logic [SEC_W-1:0]   msg_sec_q;
    logic [NS_W-1:0]    msg_ns_q;
    logic [7:0]         lost_q, lost_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic [31:0]        rd_word;
    logic               unused_bits;

    assign unused_bits = ^{q_rd_stat_i[7:4], q_rd_data_i[ENTRY_W-1:SEC_LSB+SEC_W]};

    // A read of the status word clears the count; a loss in that same cycle still counts.
    always_comb begin
        lost_d = lost_q;
        if (host_rd_i && (host_addr_i == ADDR_STAT)) begin
            lost_d = 8'd0;
        end
        if (hold_i && (q_rd_stat_i[3:0] == 4'hF)) begin
            lost_d = sat_inc8(lost_d);
        end
    end

    always_comb begin
        rd_word = 32'd0;
        if (host_addr_i == ADDR_STAT) begin
            rd_word = {16'd0, lost_q, 3'd0, entry_valid_i, q_rd_stat_i[3:0]};
        end else if (entry_valid_i) begin
            case (host_addr_i)
                ADDR_RX_SEC_HI:  rd_word = {16'd0, rx_sec_q[47:32]};
                ADDR_RX_SEC_LO:  rd_word = rx_sec_q[31:0];
                ADDR_RX_NS:      rd_word = rx_ns_q;
                ADDR_ID:         rd_word = {msgid_q, cksum_q, seqid_q};
                ADDR_MSG_SEC_HI: rd_word = {16'd0, msg_sec_q[47:32]};
                ADDR_MSG_SEC_LO: rd_word = msg_sec_q[31:0];
                ADDR_MSG_NS:     rd_word = msg_ns_q;
                default:         rd_word = 32'd0;
            endcase
        end
    end

    assign rd_data_d = host_rd_i ? rd_word : rd_data_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_sec_q  <= '0;
            rx_ns_q   <= '0;
            msgid_q   <= '0;
            cksum_q   <= '0;
            seqid_q   <= '0;
            msg_sec_q <= '0;
            msg_ns_q  <= '0;
            lost_q    <= '0;
            rd_data_q <= '0;
        end else begin
            lost_q    <= lost_d;
            rd_data_q <= rd_data_d;
            if (capture_i) begin
                rx_sec_q  <= q_rd_data_i[SEC_LSB +: SEC_W];
                rx_ns_q   <= q_rd_data_i[NS_LSB +: NS_W];
                msgid_q   <= q_rd_data_i[MSGID_LSB +: MSGID_W];
                cksum_q   <= q_rd_data_i[CKSUM_LSB +: CKSUM_W];
                seqid_q   <= q_rd_data_i[SEQID_LSB +: SEQID_W];
                msg_sec_q <= q_ts_data_i[TS_SEC_LSB +: SEC_W];
                msg_ns_q  <= q_ts_data_i[TS_NS_LSB +: NS_W];
            end
        end
    end

    assign host_rd_data_o = rd_data_q;

endmodule

// File: rtl/tsu_q_reader.sv
// Pops one entry from the TSU info/timestamp queues, holds it for the host and raises irq.
// Optional TSU_RD_AUTO_RELEASE_EN: a host read of the msg_ts_ns word in HOLD also releases the entry.
import tsu_pkg::*;

module tsu_q_reader #(
    parameter int RD_LAT    = 1,
    parameter int IRQ_LEVEL = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [7:0]         q_rd_stat_i,
    input  logic [ENTRY_W-1:0] q_rd_data_i,
    input  logic [TS_W-1:0]    q_ts_data_i,
    output logic               q_rd_en_o,
    input  logic               host_rd_i,
    input  logic [2:0]         host_addr_i,
    output logic [31:0]        host_rd_data_o,
    input  logic               host_ack_i,
    output logic               irq_o,
    output logic               entry_valid_o
);

    localparam logic [1:0] WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    // state | meaning
    // IDLE  | waiting for a non-empty queue
    // POP   | q_rd_en strobe for one cycle
    // WAIT  | queue read latency beyond the first cycle
    // CAPT  | queue outputs valid, latch into the register bank
    // HOLD  | entry presented to host until released
    tsu_state_e state_q;
    logic [1:0] wait_cnt_q;
    logic       q_rd_en_q;
    logic       entry_valid_q;
    logic       irq_q;
    logic       rel_ack;

`ifdef TSU_RD_AUTO_RELEASE_EN
    logic auto_rel_q;

    // Delayed one cycle so the release lands after the msg_ts_ns word has been returned.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            auto_rel_q <= 1'b0;
        end else begin
            auto_rel_q <= (state_q == ST_HOLD) && host_rd_i && (host_addr_i == ADDR_MSG_NS);
        end
    end

    assign rel_ack = (state_q == ST_HOLD) && (host_ack_i || auto_rel_q);
`else
    assign rel_ack = (state_q == ST_HOLD) && host_ack_i;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= 2'd0;
            q_rd_en_q     <= 1'b0;
            entry_valid_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            q_rd_en_q <= 1'b0;
            irq_q     <= (IRQ_LEVEL != 0) ? entry_valid_q : 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (q_rd_stat_i[3:0] != 4'd0) begin
                        state_q   <= ST_POP;
                        q_rd_en_q <= 1'b1;
                    end
                end
                ST_POP: begin
                    if (RD_LAT == 1) begin
                        state_q <= ST_CAPT;
                    end else begin
                        state_q    <= ST_WAIT;
                        wait_cnt_q <= WAIT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_q == 2'd0) begin
                        state_q <= ST_CAPT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 2'd1;
                    end
                end
                ST_CAPT: begin
                    state_q       <= ST_HOLD;
                    entry_valid_q <= 1'b1;
                    irq_q         <= 1'b1;
                end
                ST_HOLD: begin
                    if (rel_ack) begin
                        state_q       <= ST_IDLE;
                        entry_valid_q <= 1'b0;
                        irq_q         <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    tsu_q_regbank u_regbank (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .capture_i      (state_q == ST_CAPT),
        .hold_i         (state_q == ST_HOLD),
        .entry_valid_i  (entry_valid_q),
        .q_rd_stat_i    (q_rd_stat_i),
        .q_rd_data_i    (q_rd_data_i),
        .q_ts_data_i    (q_ts_data_i),
        .host_rd_i      (host_rd_i),
        .host_addr_i    (host_addr_i),
        .host_rd_data_o (host_rd_data_o)
    );

    assign q_rd_en_o     = q_rd_en_q;
    assign entry_valid_o = entry_valid_q;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_tsu_q_reader.sv
// Bench for tsu_q_reader: one instance with RD_LAT=1/level irq, one with RD_LAT=3/pulse irq.
module tb_tsu_q_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [127:0] ent_rd [16];
    logic [79:0]  ent_ts [16];

    // Instance A: RD_LAT=1, IRQ_LEVEL=1
    logic         rst_n_a = 1'b1;
    logic [3:0]   fill_a = 4'd0, pops_a = 4'd0;
    logic [7:0]   stat_a;
    logic [127:0] qd_a = '0;
    logic [79:0]  qt_a = '0;
    logic         en_a, irq_a, ev_a;
    logic         hrd_a = 1'b0, hack_a = 1'b0;
    logic [2:0]   haddr_a = 3'd0;
    logic [31:0]  hdata_a;
    int           pop_cyc_a[$];
    logic         pop_ev_a[$];

    // Instance B: RD_LAT=3, IRQ_LEVEL=0
    logic         rst_n_b = 1'b1;
    logic [3:0]   fill_b = 4'd0, pops_b = 4'd0;
    logic [7:0]   stat_b;
    logic [127:0] qd_b = '0;
    logic [79:0]  qt_b = '0;
    logic         en_b, irq_b, ev_b;
    logic         hrd_b = 1'b0, hack_b = 1'b0;
    logic [2:0]   haddr_b = 3'd0;
    logic [31:0]  hdata_b;
    logic [1:0]   sr_b = 2'd0;

    assign stat_a = {4'd0, fill_a - pops_a};
    assign stat_b = {4'd0, fill_b - pops_b};

    tsu_q_reader #(.RD_LAT(1), .IRQ_LEVEL(1)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n_a), .q_rd_stat_i(stat_a), .q_rd_data_i(qd_a),
        .q_ts_data_i(qt_a), .q_rd_en_o(en_a), .host_rd_i(hrd_a), .host_addr_i(haddr_a),
        .host_rd_data_o(hdata_a), .host_ack_i(hack_a), .irq_o(irq_a), .entry_valid_o(ev_a)
    );

    tsu_q_reader #(.RD_LAT(3), .IRQ_LEVEL(0)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n_b), .q_rd_stat_i(stat_b), .q_rd_data_i(qd_b),
        .q_ts_data_i(qt_b), .q_rd_en_o(en_b), .host_rd_i(hrd_b), .host_addr_i(haddr_b),
        .host_rd_data_o(hdata_b), .host_ack_i(hack_b), .irq_o(irq_b), .entry_valid_o(ev_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Queue models: data is valid only in the single cycle RD_LAT after the pop, garbage otherwise.
    always @(posedge clk) begin
        qd_a <= en_a ? ent_rd[pops_a] : {$urandom, $urandom, $urandom, $urandom};
        qt_a <= en_a ? ent_ts[pops_a] : {16'($urandom), $urandom, $urandom};
        if (en_a) begin
            pops_a <= pops_a + 4'd1;
            pop_cyc_a.push_back(cyc);
            pop_ev_a.push_back(ev_a);
        end
    end

    always @(posedge clk) begin
        sr_b <= {sr_b[0], en_b};
        qd_b <= sr_b[1] ? ent_rd[pops_b - 4'd1] : {$urandom, $urandom, $urandom, $urandom};
        qt_b <= sr_b[1] ? ent_ts[pops_b - 4'd1] : {16'($urandom), $urandom, $urandom};
        if (en_b) pops_b <= pops_b + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected host word from the published register map and entry layout.
    function automatic logic [31:0] exp_word(input logic [2:0] a, input int idx, input bit ev,
                                              input int lost, input logic [3:0] st);
        logic [127:0] e;
        logic [79:0]  t;
        e = ent_rd[idx];
        t = ent_ts[idx];
        if (a == 3'd0) return {16'd0, 8'(lost), 3'd0, ev, st};
        if (!ev) return 32'd0;
        case (a)
            3'd1: return {16'd0, e[111:96]};
            3'd2: return e[95:64];
            3'd3: return e[63:32];
            3'd4: return e[31:0];
            3'd5: return {16'd0, t[79:64]};
            3'd6: return t[63:32];
            default: return t[31:0];
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_a(input logic [2:0] a, input bit ack, output logic [31:0] d);
        hrd_a = 1'b1; haddr_a = a; hack_a = ack;
        step();
        hrd_a = 1'b0; hack_a = 1'b0;
        d = hdata_a;
    endtask

    task automatic rd_b(input logic [2:0] a, output logic [31:0] d);
        hrd_b = 1'b1; haddr_b = a;
        step();
        hrd_b = 1'b0;
        d = hdata_b;
    endtask

    task automatic wait_ev_a(input string tag, input int budget);
        int n;
        n = 0;
        while (!ev_a && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(ev_a), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [2:0]  a;
        logic [3:0]  base;
        int          idx;
        bit          seen;

        for (int i = 0; i < 16; i++) begin
            ent_rd[i] = {16'd0, 16'($urandom), $urandom, $urandom, $urandom};
            ent_ts[i] = {16'($urandom), $urandom, $urandom | 32'd1};
        end
        ent_rd[0][31:28]  = 4'h1;
        ent_rd[0][15:0]   = 16'h1234;
        ent_rd[0][63:32]  = 32'd500;
        ent_ts[0][79:32]  = 48'd7;

        // Reset
        #2;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        repeat (2) step();
        chk("rst_a_rd_en", 32'(en_a), 32'd0);
        chk("rst_a_rdata", hdata_a, 32'd0);
        chk("rst_a_irq", 32'(irq_a), 32'd0);
        chk("rst_a_ev", 32'(ev_a), 32'd0);
        chk("rst_b_rd_en", 32'(en_b), 32'd0);
        chk("rst_b_rdata", hdata_b, 32'd0);
        chk("rst_b_irq", 32'(irq_b), 32'd0);
        chk("rst_b_ev", 32'(ev_b), 32'd0);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        step();

        // Single entry on A
        fill_a = pops_a + 4'd1;
        step();
        chk("t1_pop", 32'(en_a), 32'd1);
        chk("t1_ev_c1", 32'(ev_a), 32'd0);
        step();
        chk("t1_pop_single", 32'(en_a), 32'd0);
        chk("t1_ev_c2", 32'(ev_a), 32'd0);
        step();
        chk("t1_ev_c3", 32'(ev_a), 32'd1);
        chk("t1_irq", 32'(irq_a), 32'd1);
        chk("t1_pops", 32'(pops_a), 32'd1);
        for (int k = 0; k < 8; k++) begin
            rd_a(3'(k), 1'b0, d);
            chk($sformatf("t1_addr%0d", k), d, exp_word(3'(k), 0, 1'b1, 0, stat_a[3:0]));
        end
        rd_a(3'd3, 1'b1, d);
        chk("t1_ack_with_read", d, 32'd500);
        chk("t1_ev_released", 32'(ev_a), 32'd0);
        chk("t1_irq_cleared", 32'(irq_a), 32'd0);
        rd_a(3'd2, 1'b0, d);
        chk("t1_empty_read", d, 32'd0);

        // Back-to-back on A with immediate ack
        base = pops_a;
        fill_a = pops_a + 4'd3;
        for (int k = 0; k < 3; k++) begin
            wait_ev_a($sformatf("t3_ev_wait%0d", k), 20);
            idx = int'(pops_a - 4'd1);
            a = 3'($urandom_range(1, 7));
            rd_a(a, 1'b1, d);
            chk($sformatf("t3_entry%0d_addr%0d", k, a), d, exp_word(a, idx, 1'b1, 0, 4'd0));
            chk($sformatf("t3_released%0d", k), 32'(ev_a), 32'd0);
        end
        repeat (8) step();
        chk("t3_pop_count", 32'(pops_a - base), 32'd3);
        for (int i = pop_cyc_a.size() - 3; i < pop_cyc_a.size(); i++) begin
            chk($sformatf("t3_spacing%0d", i), 32'(pop_cyc_a[i] - pop_cyc_a[i-1] >= 3), 32'd1);
            chk($sformatf("t3_no_pop_while_held%0d", i), 32'(pop_ev_a[i]), 32'd0);
        end

        // Host stall with full queue on A
        fill_a = pops_a + 4'd1;
        wait_ev_a("t4_ev_wait", 20);
        idx = int'(pops_a - 4'd1);
        fill_a = pops_a + 4'd15;
        repeat (20) @(posedge clk);
        #1;
        fill_a = pops_a + 4'd1;
        rd_a(3'd0, 1'b0, d);
        chk("t4_lost20", d, exp_word(3'd0, idx, 1'b1, 20, 4'd1));
        rd_a(3'd0, 1'b0, d);
        chk("t4_lost_cleared", d, exp_word(3'd0, idx, 1'b1, 0, 4'd1));
        fill_a = pops_a + 4'd15;
        repeat (300) @(posedge clk);
        #1;
        fill_a = pops_a + 4'd1;
        rd_a(3'd0, 1'b0, d);
        chk("t4_lost_sat", d, exp_word(3'd0, idx, 1'b1, 255, 4'd1));
        rd_a(3'd4, 1'b0, d);
        chk("t4_entry_kept", d, exp_word(3'd4, idx, 1'b1, 0, 4'd1));
        fill_a = pops_a;
        hack_a = 1'b1;
        step();
        hack_a = 1'b0;
        chk("t4_released", 32'(ev_a), 32'd0);

        // Spurious ack in IDLE on A
        base = pops_a;
        hack_a = 1'b1;
        step();
        hack_a = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            step();
            seen |= en_a;
        end
        chk("t5_no_pop", 32'(seen), 32'd0);
        chk("t5_ev", 32'(ev_a), 32'd0);
        chk("t5_pops", 32'(pops_a - base), 32'd0);

        // Randomised entries on A
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 4)) step();
            fill_a = pops_a + 4'd1;
            wait_ev_a($sformatf("t6_ev_wait%0d", k), 20);
            idx = int'(pops_a - 4'd1);
            for (int j = 0; j < 3; j++) begin
                a = 3'($urandom_range(0, 7));
                rd_a(a, 1'b0, d);
                chk($sformatf("t6_e%0d_addr%0d", k, a), d, exp_word(a, idx, 1'b1, 0, 4'd0));
            end
            hack_a = 1'b1;
            step();
            hack_a = 1'b0;
            chk($sformatf("t6_released%0d", k), 32'(ev_a), 32'd0);
        end

        // RD_LAT=3, pulse irq on B
        fill_b = pops_b + 4'd1;
        step();
        chk("b_pop", 32'(en_b), 32'd1);
        step();
        chk("b_pop_single", 32'(en_b), 32'd0);
        step();
        step();
        chk("b_ev_not_yet", 32'(ev_b), 32'd0);
        step();
        chk("b_ev", 32'(ev_b), 32'd1);
        chk("b_irq_pulse", 32'(irq_b), 32'd1);
        step();
        chk("b_irq_one_cycle", 32'(irq_b), 32'd0);
        chk("b_ev_held", 32'(ev_b), 32'd1);
        idx = int'(pops_b - 4'd1);
        rd_b(3'd2, d);
        chk("b_addr2", d, exp_word(3'd2, idx, 1'b1, 0, 4'd0));
        rd_b(3'd7, d);
        chk("b_addr7", d, exp_word(3'd7, idx, 1'b1, 0, 4'd0));
        hack_b = 1'b1;
        step();
        hack_b = 1'b0;
        chk("b_released", 32'(ev_b), 32'd0);

        // Reset during WAIT on B
        fill_b = pops_b + 4'd1;
        step();
        chk("b_rst_pop", 32'(en_b), 32'd1);
        step();
        #2;
        rst_n_b = 1'b0;
        #1;
        chk("b_rst_rd_en", 32'(en_b), 32'd0);
        chk("b_rst_ev", 32'(ev_b), 32'd0);
        chk("b_rst_irq", 32'(irq_b), 32'd0);
        chk("b_rst_rdata", hdata_b, 32'd0);
        fill_b = pops_b;
        base = pops_b;
        step();
        rst_n_b = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            step();
            seen |= en_b | ev_b;
        end
        chk("b_idle_after_rst", 32'(seen), 32'd0);
        chk("b_pops_after_rst", 32'(pops_b - base), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tsu_q_reader.md
Name: tsu_q_reader

Overview:
- Downstream consumer of the TSU timestamp queues, running in the queue read-clock domain.
- Pops one entry at a time from the 128-bit info queue and the 80-bit message-timestamp queue using a shared read strobe.
- Holds the popped entry in a register bank and exposes it to the host through a word-addressed 32-bit read port.
- Raises an interrupt while an entry is held; the host releases the entry by acknowledging it.

Parameters:
- RD_LAT, 1, cycles from q_rd_en to valid q_rd_data/q_ts_data (legal 1..3).
- IRQ_LEVEL, 1, 1 = irq is a level while an entry is held; 0 = one-cycle pulse on capture.

Ports:
- clk  in  1  queue read clock; drives the tsu q_rd_clk.
- rst_n  in  1  asynchronous active-low reset.
- q_rd_stat  in  8  tsu queue status; [3:0] = entries used.
- q_rd_data  in  128  {16'd0, rx_ts_sec[47:0], rx_ts_ns[31:0], msgid[3:0], cksum[11:0], seqid[15:0]}.
- q_ts_data  in  80  {msg_ts_sec[47:0], msg_ts_ns[31:0]}.
- q_rd_en  out  1  single-cycle pop strobe to both queues.
- host_rd  in  1  host read strobe.
- host_addr  in  3  word select.
- host_rd_data  out  32  read data, valid the cycle after host_rd.
- host_ack  in  1  release the held entry (pulse).
- irq  out  1  entry-available interrupt.
- entry_valid  out  1  an entry is held.

Behaviour:
- Reset values: q_rd_en=0, host_rd_data=0, irq=0, entry_valid=0, all holding registers 0, FSM in IDLE, lost counter 0.
- FSM states: IDLE, POP, WAIT, CAPT, HOLD.
- IDLE→POP when q_rd_stat[3:0]!=0.
- POP: q_rd_en=1 for exactly one cycle, then go to WAIT.
- WAIT: counts RD_LAT-1 cycles; with RD_LAT=1 it is skipped, giving POP→CAPT directly.
- CAPT: registers q_rd_data and q_ts_data; entry_valid goes to 1 the next cycle; go to HOLD.
- HOLD: remain until host_ack=1, then go to IDLE.
- Minimum spacing between pops is RD_LAT+2 cycles. This guarantees the rdusedw update lag never causes a pop of an empty queue.
- host_ack outside HOLD is ignored.
- host_ack coinciding with host_rd: the read returns the pre-release data.
- Register map, read by host_addr:
  - 0: {16'd0, lost_cnt[7:0], 3'd0, entry_valid, q_rd_stat[3:0]}
  - 1: {16'd0, rx_ts_sec[47:32]}
  - 2: rx_ts_sec[31:0]
  - 3: rx_ts_ns
  - 4: {msgid, cksum, seqid}
  - 5: {16'd0, msg_ts_sec[47:32]}
  - 6: msg_ts_sec[31:0]
  - 7: msg_ts_ns
- Addresses 1..7 read 0 when entry_valid=0.
- host_rd_data is registered and holds its value until the next host_rd.
- irq, IRQ_LEVEL=1: irq = entry_valid.
- irq, IRQ_LEVEL=0: one-cycle pulse in the cycle entry_valid rises.
- lost_cnt increments, saturating at 255, on each cycle in HOLD where q_rd_stat[3:0]==15, i.e. the queue is full while the host stalls. It is cleared by a read of address 0.
- Reset mid-operation: the FSM returns to IDLE immediately and any in-flight pop is discarded. The queues are reset separately via q_rst.

Optional Feature:
- Macro TSU_RD_AUTO_RELEASE_EN.
- Defined: a host_rd of address 7 while in HOLD acts as host_ack, taking effect the cycle after the data is returned; an explicit host_ack still works.
- Undefined: release happens only via host_ack, and reads have no side effects apart from the lost_cnt clear on address 0.

Decomposition:
- Shared package tsu_pkg holds:
  - field offsets and widths of the 128-bit entry: MSGID_LSB=28, CKSUM_LSB=16, SEQID_LSB=0, NS_LSB=32, SEC_LSB=64;
  - register-map address constants ADDR_STAT..ADDR_MSG_NS;
  - the FSM state enum.
- One natural sub-module: tsu_q_regbank (holding registers, address mux, lost_cnt). The FSM stays in the top.

Test Plan:
- Single entry:
  - Stimulus: q_rd_stat=1; model queue returns q_rd_data with msgid=4'h1, seqid=16'h1234, rx_ns=32'd500, and q_ts_data sec=48'd7; RD_LAT=1.
  - Response: one q_rd_en pulse; entry_valid=1 three cycles after IDLE exit; addr4 reads {4'h1, cksum, 16'h1234}; addr3 reads 500; addr6 reads 7.
- Back-to-back:
  - Stimulus: q_rd_stat=3, host acks each entry immediately.
  - Response: three pops, never fewer than RD_LAT+2 cycles apart; no pop while entry_valid=1.
- Host stall:
  - Stimulus: q_rd_stat=15 held for 20 cycles in HOLD.
  - Response: addr0 lost_cnt=20 and zero on the following addr0 read; saturates at 255 after 300 cycles.
- Spurious ack:
  - Stimulus: host_ack in IDLE with q_rd_stat=0.
  - Response: no state change; q_rd_en stays 0.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during WAIT with RD_LAT=3.
  - Response: all outputs 0 asynchronously; after release with q_rd_stat=0 the block stays idle.
- Auto-release:
  - Stimulus: TSU_RD_AUTO_RELEASE_EN defined, read addr7 in HOLD.
  - Response: addr7 returns msg_ts_ns, entry_valid falls the next cycle, and the next pop follows if q_rd_stat!=0.
